// File: rtl/cpu4_wb_arbiter.sv
// cpu4_wb_arbiter
// Shares the single regfile write port between the ALU and LSU writeback paths.
// Live requests (valid with a non-zero destination) are arbitrated round-robin,
// and the winner is registered into one output stage that drives the regfile.
// Writes to r0 are acknowledged immediately and dropped; they never use the port.
// The staged write is forwarded onto both read ports so readers never see stale data.
// A saturating counter records how many cycles both requesters were live.

module cpu4_wb_arbiter #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [AW-1:0]    alu_rdidx,
    input  logic [DW-1:0]    alu_rddata,

    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [AW-1:0]    lsu_rdidx,
    input  logic [DW-1:0]    lsu_rddata,

    output logic             rf_wen,
    output logic [AW-1:0]    rf_rdidx,
    output logic [DW-1:0]    rf_rddata,

    input  logic [AW-1:0]    rs1idx,
    input  logic [AW-1:0]    rs2idx,
    input  logic [DW-1:0]    rf_rs1data,
    input  logic [DW-1:0]    rf_rs2data,
    output logic [DW-1:0]    rs1data,
    output logic [DW-1:0]    rs2data,

    output logic [CNT_W-1:0] conflict_cnt
);

    // Round-robin pointer: which requester wins the next contested cycle.
    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LSU = 1'b1
    } rrPtr_t;

    localparam logic [AW-1:0]    ZERO_IDX = '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    rrPtr_t           rrPtr_q;
    rrPtr_t           rrPtr_d;

    logic             rfWen_q;
    logic             rfWen_d;
    logic [AW-1:0]    rfIdx_q;
    logic [AW-1:0]    rfIdx_d;
    logic [DW-1:0]    rfData_q;
    logic [DW-1:0]    rfData_d;

    logic [CNT_W-1:0] conflictCnt_q;
    logic [CNT_W-1:0] conflictCnt_d;

    logic             aluLive;
    logic             lsuLive;
    logic             bothLive;
    logic             aluDrop;
    logic             lsuDrop;
    logic             grantAlu;
    logic             grantLsu;
    logic             anyGrant;
    logic             fwd1;
    logic             fwd2;

    // Classify each request: live requests compete for the port, r0 writes are dropped.
    always_comb begin
        aluLive  = alu_valid && (alu_rdidx != ZERO_IDX);
        lsuLive  = lsu_valid && (lsu_rdidx != ZERO_IDX);
        aluDrop  = alu_valid && (alu_rdidx == ZERO_IDX);
        lsuDrop  = lsu_valid && (lsu_rdidx == ZERO_IDX);
        bothLive = aluLive && lsuLive;
    end

    // Pick at most one live winner; the pointer only matters when both are live.
    always_comb begin
        grantAlu = 1'b0;
        grantLsu = 1'b0;
        if (!reset) begin
            if (bothLive) begin
                if (rrPtr_q == RR_ALU) begin
                    grantAlu = 1'b1;
                end else begin
                    grantLsu = 1'b1;
                end
            end else if (aluLive) begin
                grantAlu = 1'b1;
            end else if (lsuLive) begin
                grantLsu = 1'b1;
            end
        end
        anyGrant = grantAlu || grantLsu;
    end

    // Handshake: a winner or a dropped r0 write is accepted in the same cycle; nothing while in reset.
    always_comb begin
        alu_ready = !reset && (grantAlu || aluDrop);
        lsu_ready = !reset && (grantLsu || lsuDrop);
    end

    // Next state for the pointer, the write stage and the conflict counter.
    always_comb begin
        rrPtr_d       = rrPtr_q;
        rfWen_d       = anyGrant;
        rfIdx_d       = rfIdx_q;
        rfData_d      = rfData_q;
        conflictCnt_d = conflictCnt_q;

        if (grantAlu) begin
            rrPtr_d  = RR_LSU;
            rfIdx_d  = alu_rdidx;
            rfData_d = alu_rddata;
        end else if (grantLsu) begin
            rrPtr_d  = RR_ALU;
            rfIdx_d  = lsu_rdidx;
            rfData_d = lsu_rddata;
        end

        if (bothLive && (conflictCnt_q != CNT_MAX)) begin
            conflictCnt_d = conflictCnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rrPtr_q       <= RR_ALU;
            rfWen_q       <= 1'b0;
            rfIdx_q       <= '0;
            rfData_q      <= '0;
            conflictCnt_q <= '0;
        end else begin
            rrPtr_q       <= rrPtr_d;
            rfWen_q       <= rfWen_d;
            rfIdx_q       <= rfIdx_d;
            rfData_q      <= rfData_d;
            conflictCnt_q <= conflictCnt_d;
        end
    end

    // A write staged just before reset rises must not reach the regfile, so the enable is masked by reset.
    always_comb begin
        rf_wen       = rfWen_q && !reset;
        rf_rdidx     = rfIdx_q;
        rf_rddata    = rfData_q;
        conflict_cnt = conflictCnt_q;
    end

    // Bypass the staged write onto the read ports; r0 always reads from the regfile.
    always_comb begin
        fwd1    = rf_wen && (rf_rdidx == rs1idx) && (rs1idx != ZERO_IDX);
        fwd2    = rf_wen && (rf_rdidx == rs2idx) && (rs2idx != ZERO_IDX);
        rs1data = fwd1 ? rf_rddata : rf_rs1data;
        rs2data = fwd2 ? rf_rddata : rf_rs2data;
    end

endmodule
